// File: rtl/seg7_pkg.sv
// Shared types and constants for the remainder display driver:
// converter state encoding, active-high segment patterns and the divide step.
package seg7_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int DIV10_STEP = 10;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-to-segment decoder with dash and blank overrides.
// Output is active-high; polarity is applied by the caller.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else if (blank) begin
            seg = SEG_BLANK;
        end else if (digit < 4'd10) begin
            seg = SEG_DIGIT[digit];
        end
    end

endmodule

// File: rtl/remain_7seg_driver.sv
// Captures a mod-100 remainder, splits it into tens/ones by repeated
// subtraction, and scans the two digits onto a multiplexed 7-segment display.
module remain_7seg_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic [6:0] value_in,
    output logic       busy,
    output logic       err,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int         CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] STEP     = 7'(DIV10_STEP);
    localparam logic [6:0] MAX_VAL  = 7'd99;
    localparam logic [6:0] SEG_RST  = SEG_ACTIVE_LOW ? ~SEG_DIGIT[0] : SEG_DIGIT[0];
    localparam logic [1:0] AN_RST   = SEG_ACTIVE_LOW ? 2'b10 : 2'b01;

    state_t     state_q, state_d;
    logic [6:0] acc_q, acc_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] disp_tens_q, disp_tens_d;
    logic [3:0] disp_ones_q, disp_ones_d;
    logic       err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       sel_q, sel_d;
    logic [6:0] seg_q, seg_d;
    logic [1:0] an_q, an_d;

    logic [3:0] mux_digit;
    logic       mux_blank;
    logic [6:0] seg_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            tens_q      <= '0;
            disp_tens_q <= '0;
            disp_ones_q <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            seg_q       <= SEG_RST;
            an_q        <= AN_RST;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tens_q      <= tens_d;
            disp_tens_q <= disp_tens_d;
            disp_ones_q <= disp_ones_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_in && (value_in <= MAX_VAL)) state_d = CONV;
            CONV:    if (acc_q < STEP) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == CONV);
    end

    // Conversion datapath; display digits only move on the committing edge.
    always_comb begin
        acc_d       = acc_q;
        tens_d      = tens_q;
        disp_tens_d = disp_tens_q;
        disp_ones_d = disp_ones_q;
        err_d       = err_q;
        if (state_q == IDLE) begin
            if (valid_in) begin
                if (value_in <= MAX_VAL) begin
                    acc_d  = value_in;
                    tens_d = '0;
                    err_d  = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else begin
            if (acc_q >= STEP) begin
                acc_d  = acc_q - STEP;
                tens_d = tens_q + 4'd1;
            end else begin
                disp_tens_d = tens_q;
                disp_ones_d = acc_q[3:0];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        sel_d = sel_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            sel_d = ~sel_q;
        end
    end

    always_comb begin
        mux_digit = sel_q ? disp_tens_q : disp_ones_q;
        mux_blank = sel_q && BLANK_LEADING && (disp_tens_q == 4'd0);
    end

    seg7_decode u_decode (
        .digit (mux_digit),
        .blank (mux_blank),
        .dash  (err_q),
        .seg   (seg_raw)
    );

    // seg and an register together so both switch on the same edge.
    always_comb begin
        seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        an_d  = sel_q ? 2'b10 : 2'b01;
        if (SEG_ACTIVE_LOW) an_d = ~an_d;
    end

    assign err = err_q;
    assign seg = seg_q;
    assign an  = an_q;

endmodule
